// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_if
// Brief    : EX-stage handshake/bus bundle between pipeline and mul/div unit.
// Revision : 1.0
// ============================================================================
interface ex_muldiv_if;
    logic        start_i;
    logic [2:0]  op_i;
    logic        word_i;
    logic [63:0] src1_i;
    logic [63:0] src2_i;
    logic        flush_i;
    logic        hold_i;
    logic        stall_req_o;
    logic        done_o;
    logic [63:0] result_o;
    logic        busy_o;

    modport master (
        output start_i, op_i, word_i, src1_i, src2_i, flush_i, hold_i,
        input  stall_req_o, done_o, result_o, busy_o
    );

    modport slave (
        input  start_i, op_i, word_i, src1_i, src2_i, flush_i, hold_i,
        output stall_req_o, done_o, result_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : RV64 M-extension iterative multiply/divide unit for the EX stage.
//            Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
// Revision : 1.0
// ============================================================================
module ex_muldiv (
    input  wire logic  clk,
    input  wire logic  rst,
    ex_muldiv_if.slave bus
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [6:0] CNT_W64   = 7'd64;
    localparam logic [6:0] CNT_W32   = 7'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [6:0]     cnt_q;
    logic [127:0]   acc_q;
    logic [63:0]    mag_q;
    logic [2:0]     op_q;
    logic           word_q;
    logic           neg_q;
    logic           rneg_q;
    logic           done_q;
    logic [63:0]    result_q;

    logic           w_accept;
    logic [2:0]     w_op;
    logic [63:0]    w_sx1, w_sx2, w_zx1, w_zx2;
    logic           w_neg1, w_neg2;
    logic [63:0]    w_mag1, w_mag2;
    logic           w_dz, w_ovf;
    logic [63:0]    w_special_res;

    logic [64:0]    w_mul_sum;
    logic [127:0]   w_mul_next;
    logic [64:0]    w_rem_sh;
    logic           w_div_ge;
    logic [63:0]    w_div_sub;
    logic [127:0]   w_div_next;
    logic [127:0]   w_step_acc;
    logic [127:0]   w_fin_src;

`ifdef MULDIV_FAST_MUL_EN
    logic [127:0]   w_fast_prod;
    assign w_fast_prod = w_mag1 * w_mag2;
`endif

    // Multiply input is a normalised magnitude product; divide input is {rem, quo}.
    function automatic logic [63:0] f_finish(
        input logic [2:0]   op,
        input logic         word,
        input logic         neg,
        input logic         rneg,
        input logic [127:0] acc
    );
        logic [127:0] p;
        logic [63:0]  q;
        logic [63:0]  r;
        logic [63:0]  v;
        p = neg  ? (128'd0 - acc) : acc;
        q = neg  ? (64'd0 - acc[63:0])   : acc[63:0];
        r = rneg ? (64'd0 - acc[127:64]) : acc[127:64];
        if (!op[2]) begin
            v = (op == OP_MUL) ? p[63:0] : p[127:64];
        end else begin
            v = op[1] ? r : q;
        end
        if (word) begin
            v = {{32{v[31]}}, v[31:0]};
        end
        return v;
    endfunction

    assign w_accept = (state_q == IDLE) && bus.start_i && !bus.flush_i && !rst;

    always_comb begin
        w_op = bus.op_i;
        if (bus.word_i && !bus.op_i[2]) begin
            w_op = OP_MUL;
        end
        w_sx1 = bus.word_i ? {{32{bus.src1_i[31]}}, bus.src1_i[31:0]} : bus.src1_i;
        w_sx2 = bus.word_i ? {{32{bus.src2_i[31]}}, bus.src2_i[31:0]} : bus.src2_i;
        w_zx1 = bus.word_i ? {32'd0, bus.src1_i[31:0]} : bus.src1_i;
        w_zx2 = bus.word_i ? {32'd0, bus.src2_i[31:0]} : bus.src2_i;

        w_neg1 = w_sx1[63] && (w_op == OP_MUL || w_op == OP_MULH || w_op == OP_MULHSU ||
                               w_op == OP_DIV || w_op == OP_REM);
        w_neg2 = w_sx2[63] && (w_op == OP_MUL || w_op == OP_MULH ||
                               w_op == OP_DIV || w_op == OP_REM);
        w_mag1 = w_neg1 ? (64'd0 - w_sx1) : w_zx1;
        w_mag2 = w_neg2 ? (64'd0 - w_sx2) : w_zx2;

        // Corner cases resolved at accept time so they never enter CALC.
        w_dz  = w_op[2] && (w_zx2 == 64'd0);
        w_ovf = w_op[2] && !w_op[0] &&
                (bus.word_i ? (bus.src1_i[31:0] == 32'h8000_0000 &&
                               bus.src2_i[31:0] == 32'hFFFF_FFFF)
                            : (bus.src1_i == 64'h8000_0000_0000_0000 &&
                               bus.src2_i == 64'hFFFF_FFFF_FFFF_FFFF));
        if (w_dz) begin
            w_special_res = w_op[1] ? w_sx1 : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (w_ovf) begin
            w_special_res = w_op[1] ? 64'd0 : w_sx1;
        end else begin
            w_special_res = 64'd0;
        end
    end

    // Shift-add multiply: add multiplicand into the top half, then shift right.
    assign w_mul_sum  = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, mag_q} : 65'd0);
    assign w_mul_next = {w_mul_sum, acc_q[63:1]};

    // Restoring divide: shift {rem, quo} left, trial-subtract divisor.
    assign w_rem_sh   = acc_q[127:63];
    assign w_div_ge   = (w_rem_sh >= {1'b0, mag_q});
    assign w_div_sub  = w_rem_sh[63:0] - mag_q;
    assign w_div_next = w_div_ge ? {w_div_sub, acc_q[62:0], 1'b1} : {acc_q[126:0], 1'b0};

    assign w_step_acc = op_q[2] ? w_div_next : w_mul_next;
    assign w_fin_src  = op_q[2] ? w_div_next :
                        (word_q ? {32'd0, w_mul_next[127:32]} : w_mul_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 7'd0;
            acc_q    <= 128'd0;
            mag_q    <= 64'd0;
            op_q     <= OP_MUL;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 64'd0;
        end else if (bus.flush_i) begin
            state_q  <= IDLE;
            cnt_q    <= 7'd0;
            done_q   <= 1'b0;
            result_q <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        op_q   <= w_op;
                        word_q <= bus.word_i;
                        neg_q  <= w_neg1 ^ w_neg2;
                        rneg_q <= w_neg1;
                        if (w_dz || w_ovf) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= w_special_res;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!w_op[2]) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= f_finish(w_op, bus.word_i, w_neg1 ^ w_neg2,
                                                 1'b0, w_fast_prod);
`endif
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= bus.word_i ? CNT_W32 : CNT_W64;
                            if (w_op[2]) begin
                                mag_q <= w_mag2;
                                acc_q <= bus.word_i ? {64'd0, w_mag1[31:0], 32'd0}
                                                    : {64'd0, w_mag1};
                            end else begin
                                mag_q <= w_mag1;
                                acc_q <= {64'd0, w_mag2};
                            end
                        end
                    end
                end
                CALC: begin
                    acc_q <= w_step_acc;
                    cnt_q <= cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        result_q <= f_finish(op_q, word_q, neg_q, rneg_q, w_fin_src);
                    end
                end
                DONE: begin
                    if (!bus.hold_i) begin
                        state_q  <= IDLE;
                        done_q   <= 1'b0;
                        result_q <= 64'd0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    done_q   <= 1'b0;
                    result_q <= 64'd0;
                end
            endcase
        end
    end

    assign bus.stall_req_o = w_accept || (state_q == CALC);
    assign bus.done_o      = done_q;
    assign bus.result_o    = result_q;
    assign bus.busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Brief    : Directed scoreboard bench for ex_muldiv.
// Revision : 1.0
// ============================================================================
module tb_ex_muldiv;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MNEG = 64'h8000_0000_0000_0000;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LM64 = 1;
    localparam int LM32 = 1;
    localparam logic [2:0] RST_OP = OP_DIV;
`else
    localparam int LM64 = 65;
    localparam int LM32 = 33;
    localparam logic [2:0] RST_OP = OP_MUL;
`endif
    localparam int LD64 = 65;
    localparam int LD32 = 33;

    typedef struct {
        logic [63:0] res;
        int          due;
        int          dur;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t sb[$];
    exp_t cur;
    logic in_done;
    int   dlen;

    ex_muldiv_if bus ();

    ex_muldiv u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: pops one expectation per done_o pulse, then checks hold stability and length.
    always @(negedge clk) begin
        if (rst) begin
            in_done = 1'b0;
        end else if (bus.done_o) begin
            if (!in_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                    cur = '{res: 64'd0, due: cyc, dur: 1};
                end else begin
                    cur = sb.pop_front();
                    chk("result", bus.result_o, cur.res);
                    chk("latency", cyc, cur.due);
                end
                in_done = 1'b1;
                dlen    = 1;
            end else begin
                dlen++;
                chk("hold_stable", bus.result_o, cur.res);
            end
        end else begin
            chk("result_zero_idle", bus.result_o, 64'd0);
            if (in_done) begin
                chk("done_length", dlen, cur.dur);
                in_done = 1'b0;
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] expv,
                         input int lat, input int hold);
        int stalls;
        int n;
        stalls = 0;
        n      = 0;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.word_i  = w;
        bus.src1_i  = a;
        bus.src2_i  = b;
        bus.hold_i  = (hold > 0);
        sb.push_back('{res: expv, due: cyc + lat, dur: hold + 1});
        #1;
        while (!bus.done_o && n < 300) begin
            if (bus.stall_req_o) stalls++;
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("done_timeout", 64'd1, 64'd0);
        end
        chk("stall_cycles", stalls, lat);
        chk("stall_low_in_done", {63'd0, bus.stall_req_o}, 64'd0);
        repeat (hold) @(negedge clk);
        bus.hold_i = 1'b0;
        @(negedge clk);
        chk("no_reaccept", {63'd0, bus.busy_o}, 64'd0);
        bus.start_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        in_done = 1'b0;
        dlen  = 0;
        rst   = 1'b1;
        bus.start_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.word_i  = 1'b0;
        bus.src1_i  = 64'd0;
        bus.src2_i  = 64'd0;
        bus.flush_i = 1'b0;
        bus.hold_i  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done",   {63'd0, bus.done_o}, 64'd0);
        chk("rst_stall",  {63'd0, bus.stall_req_o}, 64'd0);
        chk("rst_busy",   {63'd0, bus.busy_o}, 64'd0);
        chk("rst_result", bus.result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(OP_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, LM64, 0);
        issue(OP_DIV,    1'b1, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1, 0);
        issue(OP_REMU,   1'b0, 64'd100, 64'd0, 64'd100, 1, 0);
        issue(OP_DIVU,   1'b0, 64'd100, 64'd0, ONES, 1, 0);
        issue(OP_MULHU,  1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, LM64, 3);
        issue(OP_MULH,   1'b0, MNEG, 64'd2, ONES, LM64, 0);
        issue(OP_MULHSU, 1'b0, ONES, ONES, ONES, LM64, 0);
        issue(OP_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 64'hFFFF_FFFF_FFFF_FF72, LD64, 0);
        issue(OP_DIVU,   1'b0, 64'd1000, 64'd7, 64'h8E, LD64, 0);
        issue(OP_DIV,    1'b0, MNEG, ONES, MNEG, 1, 0);
        issue(OP_REM,    1'b0, MNEG, ONES, 64'd0, 1, 0);
        issue(OP_DIVU,   1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, LD32, 0);
        issue(OP_REM,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, ONES, LD32, 0);

        // Flush and start together: no accept.
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = OP_DIV;
        bus.word_i  = 1'b0;
        bus.src1_i  = 64'd1000;
        bus.src2_i  = 64'd7;
        #1;
        chk("flush_start_stall", {63'd0, bus.stall_req_o}, 64'd0);
        @(negedge clk);
        chk("flush_start_busy", {63'd0, bus.busy_o}, 64'd0);
        bus.flush_i = 1'b0;

        // Accept DIV 1000/7, flush in CALC cycle 10.
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_busy", {63'd0, bus.busy_o}, 64'd0);
        dcnt = 0;
        repeat (70) begin
            if (bus.done_o) dcnt++;
            @(negedge clk);
        end
        chk("flush_no_done", dcnt, 0);
        issue(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 64'hFFFF_FFFF_FFFF_FFFA, LD64, 0);

        // Reset in CALC cycle 20 discards the operation.
        bus.start_i = 1'b1;
        bus.op_i    = RST_OP;
        bus.word_i  = 1'b0;
        bus.src1_i  = 64'd5;
        bus.src2_i  = 64'd6;
        repeat (20) @(negedge clk);
        chk("calc_busy", {63'd0, bus.busy_o}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_done",   {63'd0, bus.done_o}, 64'd0);
        chk("mid_rst_stall",  {63'd0, bus.stall_req_o}, 64'd0);
        chk("mid_rst_busy",   {63'd0, bus.busy_o}, 64'd0);
        chk("mid_rst_result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(OP_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LM32, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
